ctrl_seq_ldst: RTL and testbench
================================

Name: ctrl_seq_ldst

Overview:
Parametrised, Moore-style control-unit sequencer for the ARM-subset datapath. It drives the datapath load strobes, the memory handshake signals (MOV, RW and typeData, with MOC as the return) and the mux selects through fetch, decode and execute. Compared with the fixed control unit it adds three things: a configurable MOC timeout with bounded retry, condition-fail skipping, and illegal-opcode and bus-error fault reporting. It sits between IR/flag logic and the register file, ALU and MAR/MDR/RAM path.

Parameters:
IR_W, 32, instruction register width; decode bit positions below assume 32.
TO_W, 4, width of the MOC wait counter.
TIMEOUT, 15, MOC wait cycles before an attempt is abandoned; 0 = wait forever (no timeout).
RETRIES, 1, extra attempts after a timeout before a bus fault is declared.

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  synchronous reset, active-high
MOC  in  1  memory operation complete, sampled on CLK rise
ir  in  IR_W  current IR contents
cond_pass  in  1  condition tester result for ir[31:28] and the current flags
RFLd  out  1  register file load
IRLd  out  1  instruction register load
MARLd  out  1  MAR load
MDRLd  out  1  MDR load
RW  out  1  1 = read, 0 = write
MOV  out  1  memory operation valid
typeData  out  1  1 = byte, 0 = word (= ir[22] during load/store states)
FRLd  out  1  flag register load
ma_sel  out  2  MAR source: 0 = PC, 1 = ALU out, 2 = reserved
mc_sel  out  1  RF destination: 0 = Rd (ir[15:12]), 1 = R15
fault  out  1  one-cycle fault pulse
fault_code  out  2  0 = none, 1 = bus timeout, 2 = illegal opcode; held until the next fault or CLR
state  out  4  current state code (debug)

Behaviour:
- Reset: while CLR is high at a CLK edge, state <= RESET(0), the retry and wait counters clear, and fault_code <= 0. All outputs are 0 in RESET.
- Outputs decode from state only. Exceptions: MDRLd in read-wait states and the exit decisions also use MOC.
- Next state from RESET is always FETCH_A.
- States and transitions:
  - 0 RESET -> 1.
  - 1 FETCH_A: MARLd = 1, ma_sel = 0 -> 2.
  - 2 FETCH_R: MOV = 1, RW = 1, MDRLd = MOC. MOC = 1 -> 3; else stay.
  - 3 FETCH_IR: IRLd = 1, RFLd = 1, mc_sel = 1 (PC+4) -> 4.
  - 4 DECODE (no strobes):
    - cond_pass = 0 -> 1.
    - ir[27:26] = 00 -> 5.
    - ir[27:26] = 01 -> 6.
    - ir[27:25] = 101 -> 11.
    - else -> 12.
  - 5 EXEC_DP: RFLd = 1, mc_sel = 0, FRLd = ir[20] -> 1.
  - 6 LS_ADDR: MARLd = 1, ma_sel = 1, typeData valid. ir[20] = 1 -> 7; else -> 9.
  - 7 LD_RD: MOV = 1, RW = 1, MDRLd = MOC. MOC = 1 -> 8.
  - 8 LD_WB: RFLd = 1, mc_sel = 0 -> 1.
  - 9 ST_DATA: MDRLd = 1, RW = 0 -> 10.
  - 10 ST_WR: MOV = 1, RW = 0. MOC = 1 -> 1.
  - 11 BRANCH: RFLd = 1, mc_sel = 1 -> 1.
  - 12 ILLEGAL: fault = 1, fault_code <= 2 -> 1.
  - 13 BUS_ERR: fault = 1, fault_code <= 1, MOV = 0 -> 1.
- typeData = ir[22] in states 6–10 and 0 elsewhere.
- MOC wait states are 2, 7 and 10:
  - The wait counter clears on entry and increments each cycle MOC = 0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with MOC = 0: if retries used < RETRIES, increment retries and re-enter the address state (1 for state 2, 6 for states 7/10); else go to 13.
  - The retry count clears on any MOC = 1 acceptance and on entering state 1 from anywhere other than a retry.
  - MOC = 1 in the same cycle as the counter reaching TIMEOUT counts as success.
- Latency with MOC high in the first wait cycle:
  - DP instruction: 5 cycles from FETCH_A back to FETCH_A.
  - Load: 7 cycles.
  - Store: 7 cycles.
  - Condition fail: 4 cycles.
- MOV drops on the cycle after MOC is accepted.
- CLR mid-transaction aborts immediately and drops MOV at that edge; no fault is reported.

Test Plan:
- CLR = 1 for 2 cycles, then 0: all outputs 0 during reset; state = 1 on the first edge after release, then MARLd = 1, ma_sel = 0.
- ir = E0912003, cond_pass = 1, MOC tied high: sequence 1,2,3,4,5,1; FRLd = 1 and RFLd = 1 in state 5 with mc_sel = 0.
- ir = E7D12000 (LDRB), MOC high one cycle after MOV rises: states 6,7,7,8; typeData = 1, RW = 1 and MDRLd = 1 on the MOC cycle; RFLd in 8.
- ir = E5812000 (STR), MOC high: states 9,10; RW = 0 in both; MDRLd = 1 in 9; typeData = 0.
- TIMEOUT = 4, RETRIES = 1, MOC held 0 in FETCH_R: two attempts of 4 wait cycles each, then state 13; fault = 1 for one cycle; fault_code = 1; resumes at state 1.
- ir = E6000010 (undefined, 011 class with bit 4 set, treated as 01 -> load/store unless decoded) replaced by ir = EC000000: DECODE -> 12; fault_code = 2. cond_pass = 0 with any ir: DECODE -> 1 with no strobes. CLR asserted during state 7: MOV = 0 next cycle; fault_code unchanged at 0.

Source files
------------

// File: rtl/ctrl_seq_ldst_if.sv
// Control bundle between the fetch/decode/execute sequencer and the ARM-subset
// datapath: strobes and selects outward, IR/condition/MOC inward.
interface ctrl_seq_ldst_if #(
  parameter int IR_W = 32
);
  logic            MOC;
  logic [IR_W-1:0] ir;
  logic            cond_pass;
  logic            RFLd;
  logic            IRLd;
  logic            MARLd;
  logic            MDRLd;
  logic            RW;
  logic            MOV;
  logic            typeData;
  logic            FRLd;
  logic [1:0]      ma_sel;
  logic            mc_sel;
  logic            fault;
  logic [1:0]      fault_code;
  logic [3:0]      state;

  modport master (
    input  MOC, ir, cond_pass,
    output RFLd, IRLd, MARLd, MDRLd, RW, MOV, typeData, FRLd,
           ma_sel, mc_sel, fault, fault_code, state
  );

  modport slave (
    output MOC, ir, cond_pass,
    input  RFLd, IRLd, MARLd, MDRLd, RW, MOV, typeData, FRLd,
           ma_sel, mc_sel, fault, fault_code, state
  );
endinterface

// File: rtl/ctrl_seq_ldst.sv
// Moore sequencer for fetch/decode/execute with MOC timeout, bounded retry,
// condition-fail skip and illegal-opcode / bus-error fault reporting.
module ctrl_seq_ldst #(
  parameter int IR_W    = 32,
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15,
  parameter int RETRIES = 1
) (
  input logic             CLK,
  input logic             CLR,
  ctrl_seq_ldst_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH_A  = 4'd1,
    S_FETCH_R  = 4'd2,
    S_FETCH_IR = 4'd3,
    S_DECODE   = 4'd4,
    S_EXEC_DP  = 4'd5,
    S_LS_ADDR  = 4'd6,
    S_LD_RD    = 4'd7,
    S_LD_WB    = 4'd8,
    S_ST_DATA  = 4'd9,
    S_ST_WR    = 4'd10,
    S_BRANCH   = 4'd11,
    S_ILLEGAL  = 4'd12,
    S_BUS_ERR  = 4'd13
  } state_t;

  localparam int                 LP_RT_W    = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [LP_RT_W-1:0] LP_RT_MAX  = LP_RT_W'(RETRIES);
  localparam logic [TO_W-1:0]    LP_TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  // Decode bit positions relative to the IR top: opcode class [27:25], B [22], L/S [20]
  localparam int LP_OPC = IR_W - 5;
  localparam int LP_B   = IR_W - 10;
  localparam int LP_S   = IR_W - 12;

  state_t               r_state;
  logic [TO_W-1:0]      r_wait;
  logic [LP_RT_W-1:0]   r_retry;
  logic [1:0]           r_fault_code;
  logic                 r_rfld;
  logic                 r_irld;
  logic                 r_marld;
  logic                 r_ma_alu;
  logic                 r_mov;
  logic                 r_rd;
  logic                 r_mdr_st;
  logic                 r_ls;
  logic                 r_dp;
  logic                 r_mc_pc;
  logic                 r_fault;

  state_t               w_nxt;
  logic                 w_wait_st;
  logic                 w_timeout;
  logic                 w_retry;

  assign w_wait_st = (r_state == S_FETCH_R) || (r_state == S_LD_RD) || (r_state == S_ST_WR);
  assign w_timeout = (TIMEOUT != 0) && w_wait_st && !bus.MOC && (r_wait == LP_TO_LAST);
  assign w_retry   = w_timeout && (r_retry < LP_RT_MAX);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_RESET:    w_nxt = S_FETCH_A;
      S_FETCH_A:  w_nxt = S_FETCH_R;
      S_FETCH_R: begin
        if (bus.MOC)        w_nxt = S_FETCH_IR;
        else if (w_timeout) w_nxt = w_retry ? S_FETCH_A : S_BUS_ERR;
      end
      S_FETCH_IR: w_nxt = S_DECODE;
      S_DECODE: begin
        if (!bus.cond_pass)                        w_nxt = S_FETCH_A;
        else if (bus.ir[LP_OPC -: 2] == 2'b00)     w_nxt = S_EXEC_DP;
        else if (bus.ir[LP_OPC -: 2] == 2'b01)     w_nxt = S_LS_ADDR;
        else if (bus.ir[LP_OPC -: 3] == 3'b101)    w_nxt = S_BRANCH;
        else                                       w_nxt = S_ILLEGAL;
      end
      S_EXEC_DP:  w_nxt = S_FETCH_A;
      S_LS_ADDR:  w_nxt = bus.ir[LP_S] ? S_LD_RD : S_ST_DATA;
      S_LD_RD: begin
        if (bus.MOC)        w_nxt = S_LD_WB;
        else if (w_timeout) w_nxt = w_retry ? S_LS_ADDR : S_BUS_ERR;
      end
      S_LD_WB:    w_nxt = S_FETCH_A;
      S_ST_DATA:  w_nxt = S_ST_WR;
      S_ST_WR: begin
        if (bus.MOC)        w_nxt = S_FETCH_A;
        else if (w_timeout) w_nxt = w_retry ? S_LS_ADDR : S_BUS_ERR;
      end
      S_BRANCH:   w_nxt = S_FETCH_A;
      S_ILLEGAL:  w_nxt = S_FETCH_A;
      S_BUS_ERR:  w_nxt = S_FETCH_A;
      default:    w_nxt = S_RESET;
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state      <= S_RESET;
      r_wait       <= '0;
      r_retry      <= '0;
      r_fault_code <= 2'd0;
      r_rfld       <= 1'b0;
      r_irld       <= 1'b0;
      r_marld      <= 1'b0;
      r_ma_alu     <= 1'b0;
      r_mov        <= 1'b0;
      r_rd         <= 1'b0;
      r_mdr_st     <= 1'b0;
      r_ls         <= 1'b0;
      r_dp         <= 1'b0;
      r_mc_pc      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_wait_st && (w_nxt == r_state)) r_wait <= r_wait + 1'b1;
      else                                 r_wait <= '0;

      if (w_retry)                                               r_retry <= r_retry + 1'b1;
      else if ((w_wait_st && bus.MOC) || (w_nxt == S_FETCH_A))   r_retry <= '0;

      if (w_nxt == S_ILLEGAL)      r_fault_code <= 2'd2;
      else if (w_nxt == S_BUS_ERR) r_fault_code <= 2'd1;

      r_rfld   <= (w_nxt inside {S_FETCH_IR, S_EXEC_DP, S_LD_WB, S_BRANCH});
      r_irld   <= (w_nxt == S_FETCH_IR);
      r_marld  <= (w_nxt inside {S_FETCH_A, S_LS_ADDR});
      r_ma_alu <= (w_nxt == S_LS_ADDR);
      r_mov    <= (w_nxt inside {S_FETCH_R, S_LD_RD, S_ST_WR});
      r_rd     <= (w_nxt inside {S_FETCH_R, S_LD_RD});
      r_mdr_st <= (w_nxt == S_ST_DATA);
      r_ls     <= (w_nxt inside {S_LS_ADDR, S_LD_RD, S_LD_WB, S_ST_DATA, S_ST_WR});
      r_dp     <= (w_nxt == S_EXEC_DP);
      r_mc_pc  <= (w_nxt inside {S_FETCH_IR, S_BRANCH});
      r_fault  <= (w_nxt inside {S_ILLEGAL, S_BUS_ERR});
    end
  end

  assign bus.RFLd       = r_rfld;
  assign bus.IRLd       = r_irld;
  assign bus.MARLd      = r_marld;
  assign bus.MDRLd      = r_mdr_st | (r_rd & bus.MOC);
  assign bus.RW         = r_rd;
  assign bus.MOV        = r_mov;
  assign bus.typeData   = r_ls & bus.ir[LP_B];
  assign bus.FRLd       = r_dp & bus.ir[LP_S];
  assign bus.ma_sel     = {1'b0, r_ma_alu};
  assign bus.mc_sel     = r_mc_pc;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_ctrl_seq_ldst.sv
// Bench for ctrl_seq_ldst: reset, hand sequences, a vector table and random
// instructions against a transaction-level model with a reactive memory.
module tb_ctrl_seq_ldst;
  localparam int TO = 4;
  localparam int RT = 1;

  logic CLK = 1'b0;
  logic CLR;

  ctrl_seq_ldst_if #(.IR_W(32)) bus ();

  ctrl_seq_ldst #(.IR_W(32), .TO_W(4), .TIMEOUT(TO), .RETRIES(RT)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int cyc; int rf; int irl; int mar; int mdr; int mov; int fr; int flt; int code;
  } res_t;

  typedef struct packed {
    logic [31:0] ir; logic cp; int d0; int d1; int d2; int cyc; int code;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   dq[$];
  int   path[$];
  int   d_cur = 0;
  int   mov_cnt = 0;
  logic prev_mov = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory answers MOC d cycles after MOV rises; one delay per attempt
  task automatic tick();
    @(posedge CLK);
    #2;
    if (bus.MOV) begin
      if (!prev_mov) begin
        d_cur   = (dq.size() > 0) ? dq.pop_front() : 0;
        mov_cnt = 0;
      end
      bus.MOC = (mov_cnt == d_cur);
      mov_cnt++;
    end else begin
      bus.MOC = 1'b0;
    end
    prev_mov = bus.MOV;
    #1;
  endtask

  function automatic logic [11:0] exp_outs(input int s, input logic [31:0] ir, input logic moc);
    logic rf, irl, mar, mdr, rw, mov, td, fr, mc, flt;
    logic [1:0] ma;
    rf  = (s == 3) || (s == 5) || (s == 8) || (s == 11);
    irl = (s == 3);
    mar = (s == 1) || (s == 6);
    mov = (s == 2) || (s == 7) || (s == 10);
    rw  = (s == 2) || (s == 7);
    mdr = (s == 9) || (rw && moc);
    td  = (s >= 6) && (s <= 10) && ir[22];
    fr  = (s == 5) && ir[20];
    ma  = (s == 6) ? 2'd1 : 2'd0;
    mc  = (s == 3) || (s == 11);
    flt = (s == 12) || (s == 13);
    return {rf, irl, mar, mdr, rw, mov, td, fr, ma, mc, flt};
  endfunction

  function automatic logic [11:0] act_outs();
    return {bus.RFLd, bus.IRLd, bus.MARLd, bus.MDRLd, bus.RW, bus.MOV, bus.typeData,
            bus.FRLd, bus.ma_sel, bus.mc_sel, bus.fault};
  endfunction

  function automatic logic [31:0] pathword();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < path.size() && i < 8; i++) w = (w << 4) | 32'(path[i] & 15);
    return w;
  endfunction

  // Transaction-level expectation: each memory access gets RT+1 attempts,
  // an attempt with delay d < TO succeeds after d+1 wait cycles.
  function automatic res_t model(input logic [31:0] ir, input logic cp, input int d[8]);
    res_t r;
    int   k;
    bit   ok;
    bit   ld;
    r = '0; r.code = -1; k = 0; ok = 0;
    for (int a = 0; a <= RT && !ok; a++) begin
      r.cyc++; r.mar++;
      if (d[k] < TO) begin r.cyc += d[k] + 1; r.mov += d[k] + 1; r.mdr++; ok = 1; end
      else begin r.cyc += TO; r.mov += TO; end
      k++;
    end
    if (!ok) begin r.cyc++; r.flt++; r.code = 1; return r; end
    r.cyc += 2; r.rf++; r.irl++;
    if (!cp) return r;
    if (ir[27:26] == 2'b00) begin
      r.cyc++; r.rf++; r.fr += int'(ir[20]);
    end else if (ir[27:26] == 2'b01) begin
      ld = ir[20]; ok = 0;
      for (int a = 0; a <= RT && !ok; a++) begin
        r.cyc++; r.mar++;
        if (!ld) begin r.cyc++; r.mdr++; end
        if (d[k] < TO) begin
          r.cyc += d[k] + 1; r.mov += d[k] + 1; ok = 1;
          if (ld) r.mdr++;
        end else begin
          r.cyc += TO; r.mov += TO;
        end
        k++;
      end
      if (!ok) begin r.cyc++; r.flt++; r.code = 1; return r; end
      if (ld) begin r.cyc++; r.rf++; end
    end else if (ir[27:25] == 3'b101) begin
      r.cyc++; r.rf++;
    end else begin
      r.cyc++; r.flt++; r.code = 2;
    end
    return r;
  endfunction

  // Runs from an observed FETCH_A until FETCH_A is re-entered other than by a fetch retry
  task automatic run_instr(input logic [31:0] ir, input logic cp, input int d[8], output res_t o);
    int budget;
    int prev_s;
    bit done;
    bus.ir = ir; bus.cond_pass = cp;
    dq.delete();
    for (int i = 0; i < 8; i++) dq.push_back(d[i]);
    o = '0; o.code = -1; path.delete(); budget = 0; done = 0;
    while (!done) begin
      path.push_back(int'(bus.state));
      check($sformatf("outdec_s%0d", bus.state), 32'(act_outs()),
            32'(exp_outs(int'(bus.state), ir, bus.MOC)));
      o.cyc++;
      o.rf  += int'(bus.RFLd);
      o.irl += int'(bus.IRLd);
      o.mar += int'(bus.MARLd);
      o.mdr += int'(bus.MDRLd);
      o.mov += int'(bus.MOV);
      o.fr  += int'(bus.FRLd);
      o.flt += int'(bus.fault);
      if (bus.fault) o.code = int'(bus.fault_code);
      prev_s = int'(bus.state);
      tick();
      budget++;
      done = ((bus.state == 4'd1) && (prev_s != 2)) || (budget >= 60);
    end
    check("instr_budget", 32'(budget < 60), 32'd1);
  endtask

  task automatic cmp_res(input string tag, input res_t o, input res_t m);
    check({tag, "_cyc"}, 32'(o.cyc), 32'(m.cyc));
    check({tag, "_rfld"}, 32'(o.rf), 32'(m.rf));
    check({tag, "_irld"}, 32'(o.irl), 32'(m.irl));
    check({tag, "_marld"}, 32'(o.mar), 32'(m.mar));
    check({tag, "_mdrld"}, 32'(o.mdr), 32'(m.mdr));
    check({tag, "_mov"}, 32'(o.mov), 32'(m.mov));
    check({tag, "_frld"}, 32'(o.fr), 32'(m.fr));
    check({tag, "_fault"}, 32'(o.flt), 32'(m.flt));
    check({tag, "_code"}, 32'(o.code), 32'(m.code));
  endtask

  initial begin
    vec_t        tbl [12];
    int          dv [8];
    res_t        o;
    res_t        m;
    int          exp_code;
    int          n;
    logic [31:0] rir;
    logic        rcp;

    tbl[0]  = '{32'hE0912003, 1'b1, 0, 0, 0,  5, -1};
    tbl[1]  = '{32'hE7D12000, 1'b1, 0, 0, 0,  7, -1};
    tbl[2]  = '{32'hE5812000, 1'b1, 0, 0, 0,  7, -1};
    tbl[3]  = '{32'hE0912003, 1'b0, 0, 0, 0,  4, -1};
    tbl[4]  = '{32'hEA000000, 1'b1, 0, 0, 0,  5, -1};
    tbl[5]  = '{32'hEC000000, 1'b1, 0, 0, 0,  5,  2};
    tbl[6]  = '{32'hE0912003, 1'b1, 3, 0, 0,  8, -1};
    tbl[7]  = '{32'hE7D12000, 1'b1, 0, 3, 0, 10, -1};
    tbl[8]  = '{32'hE5812000, 1'b1, 0, 9, 1, 14, -1};
    tbl[9]  = '{32'hE7D12000, 1'b1, 0, 9, 9, 15,  1};
    tbl[10] = '{32'hE0912003, 1'b1, 9, 0, 0, 10, -1};
    tbl[11] = '{32'hE0912003, 1'b1, 9, 9, 0, 11,  1};

    CLR = 1'b1; bus.MOC = 1'b0; bus.ir = '0; bus.cond_pass = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outs", 32'({act_outs(), bus.fault_code, bus.state}), 32'd0);
    end
    CLR = 1'b0;
    tick();
    check("rst_exit_state", 32'(bus.state), 32'd1);
    check("rst_exit_mar", 32'({bus.MARLd, bus.ma_sel}), 32'b100);
    exp_code = 0;

    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(32'hE0912003, 1'b1, dv, o);
    check("dp_path", pathword(), 32'h12345);
    check("dp_frld", 32'(o.fr), 32'd1);

    dv = '{0, 1, 0, 0, 0, 0, 0, 0};
    run_instr(32'hE7D12000, 1'b1, dv, o);
    check("ldrb_path", pathword(), 32'h12346778);
    check("ldrb_mdrld", 32'(o.mdr), 32'd2);

    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(32'hE5812000, 1'b1, dv, o);
    check("str_path", pathword(), 32'h123469A);
    check("str_mdrld", 32'(o.mdr), 32'd2);

    dv = '{9, 9, 9, 9, 9, 9, 9, 9};
    run_instr(32'hE0912003, 1'b1, dv, o);
    check("to_path", pathword(), 32'h12222122);
    check("to_cyc", 32'(o.cyc), 32'd11);
    check("to_fault_pulse", 32'(o.flt), 32'd1);
    check("to_code", 32'(o.code), 32'd1);
    check("to_resume", 32'(bus.state), 32'd1);
    check("to_code_hold", 32'(bus.fault_code), 32'd1);

    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(32'hEC000000, 1'b1, dv, o);
    check("ill_path", pathword(), 32'h1234C);
    check("ill_code_hold", 32'(bus.fault_code), 32'd2);

    run_instr(32'hE7D12000, 1'b0, dv, o);
    check("cf_path", pathword(), 32'h1234);
    check("cf_rfld", 32'(o.rf), 32'd1);

    bus.ir = 32'hE7D12000; bus.cond_pass = 1'b1;
    dq.delete(); dq.push_back(0); dq.push_back(99);
    n = 0;
    while (bus.state != 4'd7 && n < 20) begin tick(); n++; end
    check("clr_reach_ld", 32'(bus.state), 32'd7);
    CLR = 1'b1;
    tick();
    check("clr_mov", 32'(bus.MOV), 32'd0);
    check("clr_state", 32'(bus.state), 32'd0);
    check("clr_fault", 32'({bus.fault, bus.fault_code}), 32'd0);
    CLR = 1'b0;
    tick();
    check("clr_resume", 32'(bus.state), 32'd1);
    exp_code = 0;

    foreach (tbl[i]) begin
      dv = '{tbl[i].d0, tbl[i].d1, tbl[i].d2, 0, 0, 0, 0, 0};
      run_instr(tbl[i].ir, tbl[i].cp, dv, o);
      check($sformatf("tbl%0d_cyc", i), 32'(o.cyc), 32'(tbl[i].cyc));
      check($sformatf("tbl%0d_code", i), 32'(o.code), 32'(tbl[i].code));
      if (tbl[i].code != -1) exp_code = tbl[i].code;
      check($sformatf("tbl%0d_code_hold", i), 32'(bus.fault_code), 32'(exp_code));
    end

    for (int k = 0; k < 150; k++) begin
      rir = $urandom();
      rcp = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 8; i++) dv[i] = int'($urandom_range(0, 5));
      m = model(rir, rcp, dv);
      run_instr(rir, rcp, dv, o);
      cmp_res($sformatf("rnd%0d", k), o, m);
      if (m.code != -1) exp_code = m.code;
      check($sformatf("rnd%0d_code_hold", k), 32'(bus.fault_code), 32'(exp_code));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
